register_file: RTL and testbench
================================

Name: register_file

Overview:
- Integer register file for the RV32I core. Sits directly downstream of the decode stage.
- Consumes decoded rs1/rs2/rd indices and supplies operand values to execute.
- Accepts writeback from the later stages.
- Holds a per-register pending-write scoreboard, so later pipelined stages can detect RAW hazards.

Parameters:
- DWIDTH, 32, register data width.
- NREGS, 32, number of architectural registers (index width = 5).
- SP_INIT, 32'h0110_0000, reset value of x2 (stack pointer).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- rs1_i  input  5  read port 1 index (from decode rs1).
- rs2_i  input  5  read port 2 index (from decode rs2).
- rs1_data_o  output  DWIDTH  read port 1 data.
- rs2_data_o  output  DWIDTH  read port 2 data.
- rs1_busy_o  output  1  scoreboard bit of rs1_i.
- rs2_busy_o  output  1  scoreboard bit of rs2_i.
- issue_en_i  input  1  decode issues an insn that writes rd_issue_i.
- rd_issue_i  input  5  destination of the issuing insn.
- wr_en_i  input  1  writeback valid.
- rd_wr_i  input  5  writeback destination.
- wr_data_i  input  DWIDTH  writeback data.
- flush_i  input  1  clear all scoreboard bits (pipeline squash).

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Storage: NREGS x DWIDTH array.
  - x0 is hardwired: reads of index 0 always return 0, writes to x0 are ignored, busy bit of x0 is always 0.
- Reset (rst=1 at rising edge):
  - all registers cleared to 0, except x2 = SP_INIT.
  - all scoreboard bits cleared.
  - rst has priority over every other input in the same cycle.
- Read ports: combinational, zero latency. rsN_data_o = regs[rsN_i] as of the last clock edge (no bypass unless the optional feature is enabled).
- Write port:
  - if wr_en_i=1 and rd_wr_i!=0, regs[rd_wr_i] <= wr_data_i at the rising edge.
  - new value is visible on read ports in the following cycle.
- Scoreboard: one bit per register, updated at the rising edge in this priority order.
  1. rst: clear all.
  2. flush_i: clear all. Same-cycle issue is ignored; same-cycle write still updates the array.
  3. Write with wr_en_i=1, rd_wr_i!=0: clear busy[rd_wr_i].
  4. Issue with issue_en_i=1, rd_issue_i!=0: set busy[rd_issue_i].
  5. Same index issued and written in the same cycle: issue wins, bit ends set (new producer outstanding).
- Busy outputs:
  - rsN_busy_o = busy[rsN_i], combinational from registered state.
  - A write arriving in the current cycle does not clear the output until the next cycle (without the optional feature).
- Simultaneous writes: single write port; no conflict possible.
- Reset mid-operation: any in-flight write in the reset cycle is discarded.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - write-to-read forwarding. If wr_en_i=1, rd_wr_i!=0 and rd_wr_i==rsN_i, then rsN_data_o = wr_data_i combinationally.
  - rsN_busy_o is forced 0 for that index in the same cycle.
  - Never applies to x0.
- Undefined:
  - reads return only the stored array value.
  - busy reflects registered state only.
  - a same-cycle read of a register being written returns the old value.

Test Plan:
- Reset then read: rst pulse, rs1_i=2, rs2_i=5 -> rs1_data_o=32'h0110_0000, rs2_data_o=0, both busy=0.
- Write/read latency: write x5=32'hDEAD_BEEF, rs1_i=5 in the same cycle:
  - no-bypass build: old value 0 that cycle, DEAD_BEEF the next cycle.
  - REGFILE_BYPASS_EN build: DEAD_BEEF immediately.
- x0 protection: wr_en_i=1, rd_wr_i=0, wr_data_i=32'hFFFF_FFFF; issue_en_i=1, rd_issue_i=0 -> rs1_i=0 reads 0, rs1_busy_o=0.
- Scoreboard lifecycle, all with rs1_i=7:
  - issue rd=7 -> rs1_busy_o=1 the next cycle.
  - write rd=7 two cycles later -> busy=0 the cycle after the write.
  - issue and write rd=7 in the same cycle -> busy stays 1.
- Flush: set busy on x3, x4, x9, then flush_i=1 with issue_en_i=1 rd_issue_i=10 -> all busy bits 0 after the edge, including x10.
- Reset mid-operation: write x6=32'h1234 in the same cycle as rst=1 -> x6 reads 0 afterwards, x2=SP_INIT, scoreboard empty.

Source files
------------

// File: rtl/register_file.sv
// register_file: RV32I integer register file with per-register pending-write scoreboard; REGFILE_BYPASS_EN adds write-to-read forwarding.
// Latency: reads combinational, writes visible next cycle (same cycle with bypass); no backpressure, every input accepted each cycle.
module register_file #(
  parameter int                 DWIDTH  = 32,
  parameter int                 NREGS   = 32,
  parameter logic [DWIDTH-1:0]  SP_INIT = 32'h0110_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  output logic [DWIDTH-1:0] rs1_data_o,
  output logic [DWIDTH-1:0] rs2_data_o,
  output logic              rs1_busy_o,
  output logic              rs2_busy_o,
  input  logic              issue_en_i,
  input  logic [4:0]        rd_issue_i,
  input  logic              wr_en_i,
  input  logic [4:0]        rd_wr_i,
  input  logic [DWIDTH-1:0] wr_data_i,
  input  logic              flush_i
);

  logic [DWIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;

  logic wr_act;
  logic issue_act;

  assign wr_act    = wr_en_i && (rd_wr_i != 5'd0);
  assign issue_act = issue_en_i && (rd_issue_i != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= (i == 2) ? SP_INIT : '0;
      end
      busy <= '0;
    end else begin
      if (wr_act) begin
        regs[rd_wr_i] <= wr_data_i;
      end
      if (flush_i) begin
        busy <= '0;
      end else begin
        // Issue is applied after the write clear so a new producer wins on a shared index.
        if (wr_act) begin
          busy[rd_wr_i] <= 1'b0;
        end
        if (issue_act) begin
          busy[rd_issue_i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    rs1_data_o = (rs1_i == 5'd0) ? '0 : regs[rs1_i];
    rs2_data_o = (rs2_i == 5'd0) ? '0 : regs[rs2_i];
    rs1_busy_o = (rs1_i == 5'd0) ? 1'b0 : busy[rs1_i];
    rs2_busy_o = (rs2_i == 5'd0) ? 1'b0 : busy[rs2_i];
`ifdef REGFILE_BYPASS_EN
    if (wr_act && (rd_wr_i == rs1_i)) begin
      rs1_data_o = wr_data_i;
      rs1_busy_o = 1'b0;
    end
    if (wr_act && (rd_wr_i == rs2_i)) begin
      rs2_data_o = wr_data_i;
      rs2_busy_o = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed literal checks plus randomized traffic against a behavioural model.
module tb_register_file;

  localparam logic [31:0] SP = 32'h0110_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_i, rs2_i, rd_issue_i, rd_wr_i;
  logic [31:0] rs1_data_o, rs2_data_o, wr_data_i;
  logic        rs1_busy_o, rs2_busy_o, issue_en_i, wr_en_i, flush_i;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [31:0] mregs [32];
  logic [31:0] mbusy;

  register_file dut (
    .clk(clk), .rst(rst),
    .rs1_i(rs1_i), .rs2_i(rs2_i),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
    .issue_en_i(issue_en_i), .rd_issue_i(rd_issue_i),
    .wr_en_i(wr_en_i), .rd_wr_i(rd_wr_i), .wr_data_i(wr_data_i),
    .flush_i(flush_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] idx);
    if (idx == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en_i && rd_wr_i == idx) return wr_data_i;
`endif
    return mregs[idx];
  endfunction

  function automatic logic exp_busy(input logic [4:0] idx);
    if (idx == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en_i && rd_wr_i == idx) return 1'b0;
`endif
    return mbusy[idx];
  endfunction

  // Architectural state as the spec describes it: reset, then write, then scoreboard rules.
  always @(posedge clk) begin
    if (rst) begin
      foreach (mregs[i]) mregs[i] = 32'h0;
      mregs[2] = SP;
      mbusy = 32'h0;
    end else begin
      if (wr_en_i && rd_wr_i != 0) mregs[rd_wr_i] = wr_data_i;
      if (flush_i) mbusy = 32'h0;
      else begin
        if (wr_en_i && rd_wr_i != 0) mbusy[rd_wr_i] = 1'b0;
        if (issue_en_i && rd_issue_i != 0) mbusy[rd_issue_i] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_rs1_data", rs1_data_o, exp_data(rs1_i));
      chk("model_rs2_data", rs2_data_o, exp_data(rs2_i));
      chk("model_rs1_busy", {31'b0, rs1_busy_o}, {31'b0, exp_busy(rs1_i)});
      chk("model_rs2_busy", {31'b0, rs2_busy_o}, {31'b0, exp_busy(rs2_i)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; issue_en_i = 0; rd_issue_i = 0; wr_en_i = 0; rd_wr_i = 0;
    wr_data_i = 0; flush_i = 0;
  endtask

  initial begin
    idle();
    rs1_i = 0; rs2_i = 0;
    rst = 1;
    tick();
    tick();
    idle();
    chk_en = 1'b1;

    // Reset then read
    rs1_i = 2; rs2_i = 5;
    @(negedge clk);
    chk("reset_x2", rs1_data_o, 32'h0110_0000);
    chk("reset_x5", rs2_data_o, 32'h0);
    chk("reset_busy1", {31'b0, rs1_busy_o}, 32'h0);
    chk("reset_busy2", {31'b0, rs2_busy_o}, 32'h0);

    // Write/read latency on x5
    tick();
    wr_en_i = 1; rd_wr_i = 5; wr_data_i = 32'hDEAD_BEEF; rs1_i = 5;
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    chk("wr_same_cycle", rs1_data_o, 32'hDEAD_BEEF);
`else
    chk("wr_same_cycle", rs1_data_o, 32'h0);
`endif
    tick();
    idle();
    @(negedge clk);
    chk("wr_next_cycle", rs1_data_o, 32'hDEAD_BEEF);

    // x0 protection
    tick();
    wr_en_i = 1; rd_wr_i = 0; wr_data_i = 32'hFFFF_FFFF;
    issue_en_i = 1; rd_issue_i = 0; rs1_i = 0;
    @(negedge clk);
    chk("x0_data_same", rs1_data_o, 32'h0);
    tick();
    idle();
    @(negedge clk);
    chk("x0_data_next", rs1_data_o, 32'h0);
    chk("x0_busy_next", {31'b0, rs1_busy_o}, 32'h0);

    // Scoreboard lifecycle on x7
    tick();
    rs1_i = 7; issue_en_i = 1; rd_issue_i = 7;
    tick();
    idle();
    @(negedge clk);
    chk("sb_issue_busy", {31'b0, rs1_busy_o}, 32'h1);
    tick();
    wr_en_i = 1; rd_wr_i = 7; wr_data_i = 32'h0000_0777;
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    chk("sb_write_cycle", {31'b0, rs1_busy_o}, 32'h0);
`else
    chk("sb_write_cycle", {31'b0, rs1_busy_o}, 32'h1);
`endif
    tick();
    idle();
    @(negedge clk);
    chk("sb_after_write", {31'b0, rs1_busy_o}, 32'h0);
    tick();
    wr_en_i = 1; rd_wr_i = 7; wr_data_i = 32'h0000_0778; issue_en_i = 1; rd_issue_i = 7;
    tick();
    idle();
    @(negedge clk);
    chk("sb_issue_wins", {31'b0, rs1_busy_o}, 32'h1);
    chk("sb_issue_wins_data", rs1_data_o, 32'h0000_0778);

    // Flush with same-cycle issue
    tick();
    issue_en_i = 1; rd_issue_i = 3;
    tick();
    rd_issue_i = 4;
    tick();
    rd_issue_i = 9;
    tick();
    idle();
    rs1_i = 3; rs2_i = 9;
    @(negedge clk);
    chk("pre_flush_x3", {31'b0, rs1_busy_o}, 32'h1);
    chk("pre_flush_x9", {31'b0, rs2_busy_o}, 32'h1);
    flush_i = 1; issue_en_i = 1; rd_issue_i = 10;
    tick();
    idle();
    rs1_i = 4; rs2_i = 10;
    @(negedge clk);
    chk("flush_x4", {31'b0, rs1_busy_o}, 32'h0);
    chk("flush_x10", {31'b0, rs2_busy_o}, 32'h0);
    rs1_i = 3; rs2_i = 9;
    @(negedge clk);
    chk("flush_x3", {31'b0, rs1_busy_o}, 32'h0);
    chk("flush_x9", {31'b0, rs2_busy_o}, 32'h0);

    // Reset mid-operation; x7 busy is set again first
    tick();
    issue_en_i = 1; rd_issue_i = 7;
    tick();
    idle();
    rst = 1; wr_en_i = 1; rd_wr_i = 6; wr_data_i = 32'h1234;
    tick();
    idle();
    rs1_i = 6; rs2_i = 2;
    @(negedge clk);
    chk("rst_mid_x6", rs1_data_o, 32'h0);
    chk("rst_mid_x2", rs2_data_o, SP);
    rs1_i = 7; rs2_i = 5;
    @(negedge clk);
    chk("rst_mid_busy7", {31'b0, rs1_busy_o}, 32'h0);
    chk("rst_mid_x5", rs2_data_o, 32'h0);

    // Randomized traffic, checked every cycle by the compare process
    for (int n = 0; n < 3000; n++) begin
      tick();
      rst        = ($urandom_range(0, 199) == 0);
      flush_i    = ($urandom_range(0, 31) == 0);
      rs1_i      = 5'($urandom_range(0, 31));
      rs2_i      = 5'($urandom_range(0, 31));
      issue_en_i = ($urandom_range(0, 1) == 1);
      rd_issue_i = 5'($urandom_range(0, 15));
      wr_en_i    = ($urandom_range(0, 2) != 0);
      rd_wr_i    = 5'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) rd_wr_i = rs1_i;
      if ($urandom_range(0, 7) == 0) rd_issue_i = rd_wr_i;
      wr_data_i  = $urandom;
    end
    tick();
    idle();
    @(negedge clk);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
